// File: rtl/imm_gen_pipe.sv
// Immediate-generation stage: decodes RV32I/RV64I immediates into a 2-entry skid FIFO.
// Define IMMGEN_ILLEGAL_EN to compute and store the illegal-opcode flag per entry.
module imm_gen_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     in_instr_i,
    input  logic [XLEN-1:0] in_pc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [31:0]     out_instr_o,
    output logic [XLEN-1:0] out_pc_o,
    output logic [XLEN-1:0] out_imm_o,
    output logic [2:0]      out_type_o,
    output logic            out_illegal_o
);
    localparam logic [2:0] T_NONE = 3'd0, T_I = 3'd1, T_S = 3'd2,
                           T_B = 3'd3, T_U = 3'd4, T_J = 3'd5;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [2:0]      ty;
    } ent_t;

    ent_t            r_mem [2];
    logic            r_head;
    logic [1:0]      r_count;

    logic [6:0]        w_op;
    logic signed [31:0] w_imm32;
    logic [2:0]        w_type;
    logic [XLEN-1:0]   w_imm;
    logic              w_push, w_pop, w_wr_idx;

    assign w_op = in_instr_i[6:0];

    // Immediates are formed at 32 bits, then sign-extended from bit 31 to XLEN.
    always_comb begin
        w_imm32 = '0;
        w_type  = T_NONE;
        case (w_op)
            7'b0010011, 7'b0000011, 7'b1100111: begin
                w_type  = T_I;
                w_imm32 = {{20{in_instr_i[31]}}, in_instr_i[31:20]};
            end
            7'b0011011: if (XLEN == 64) begin
                w_type  = T_I;
                w_imm32 = {{20{in_instr_i[31]}}, in_instr_i[31:20]};
            end
            7'b0100011: begin
                w_type  = T_S;
                w_imm32 = {{20{in_instr_i[31]}}, in_instr_i[31:25], in_instr_i[11:7]};
            end
            7'b1100011: begin
                w_type  = T_B;
                w_imm32 = {{20{in_instr_i[31]}}, in_instr_i[7], in_instr_i[30:25],
                           in_instr_i[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                w_type  = T_U;
                w_imm32 = {in_instr_i[31:12], 12'b0};
            end
            7'b1101111: begin
                w_type  = T_J;
                w_imm32 = {{12{in_instr_i[31]}}, in_instr_i[19:12], in_instr_i[20],
                           in_instr_i[30:21], 1'b0};
            end
            default: ;
        endcase
    end

    assign w_imm = XLEN'(w_imm32);

`ifdef IMMGEN_ILLEGAL_EN
    function automatic logic f_illegal(input logic [6:0] op);
        case (op)
            7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011,
            7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b0001111,
            7'b1110011: f_illegal = 1'b0;
            7'b0011011, 7'b0111011: f_illegal = (XLEN != 64);
            default: f_illegal = 1'b1;
        endcase
    endfunction

    logic [1:0] r_ill;
`endif

    assign in_ready_o  = (r_count != 2'd2);
    assign out_valid_o = (r_count != 2'd0);
    assign w_push      = in_valid_i & in_ready_o;
    assign w_pop       = out_valid_o & out_ready_i;
    // Count 0 writes at head, count 1 writes at the other slot.
    assign w_wr_idx    = r_head ^ r_count[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 2'd0;
            r_head  <= 1'b0;
            for (int i = 0; i < 2; i++) r_mem[i] <= '0;
`ifdef IMMGEN_ILLEGAL_EN
            r_ill   <= 2'b00;
`endif
        end else if (flush_i) begin
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[w_wr_idx] <= '{instr: in_instr_i, pc: in_pc_i, imm: w_imm, ty: w_type};
`ifdef IMMGEN_ILLEGAL_EN
                r_ill[w_wr_idx] <= f_illegal(w_op);
`endif
            end
            if (w_pop) r_head <= ~r_head;
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
        end
    end

    assign out_instr_o = r_mem[r_head].instr;
    assign out_pc_o    = r_mem[r_head].pc;
    assign out_imm_o   = r_mem[r_head].imm;
    assign out_type_o  = r_mem[r_head].ty;
`ifdef IMMGEN_ILLEGAL_EN
    assign out_illegal_o = r_ill[r_head];
`else
    assign out_illegal_o = 1'b0;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances on shared stimulus,
// checked each cycle against a queue model plus directed literal expectations.
module tb_imm_gen_pipe;
    logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
    logic [31:0] in_instr = 0;
    logic [63:0] in_pc = 0;

    logic        r32, v32, il32, r64, v64, il64;
    logic [31:0] ins32, pc32, imm32, ins64;
    logic [63:0] pc64, imm64;
    logic [2:0]  t32, t64;

    int checks = 0, errors = 0;

    imm_gen_pipe #(.XLEN(32)) u32 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(r32),
        .in_instr_i(in_instr), .in_pc_i(in_pc[31:0]), .out_valid_o(v32), .out_ready_i(out_ready),
        .out_instr_o(ins32), .out_pc_o(pc32), .out_imm_o(imm32), .out_type_o(t32),
        .out_illegal_o(il32));
    imm_gen_pipe #(.XLEN(64)) u64 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(r64),
        .in_instr_i(in_instr), .in_pc_i(in_pc), .out_valid_o(v64), .out_ready_i(out_ready),
        .out_instr_o(ins64), .out_pc_o(pc64), .out_imm_o(imm64), .out_type_o(t64),
        .out_illegal_o(il64));

    always #5 clk = ~clk;

`ifdef IMMGEN_ILLEGAL_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    typedef struct { logic [31:0] instr; logic [63:0] pc; } item_t;
    item_t q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Sign-extend the low n bits of v to 64 bits.
    function automatic logic [63:0] sx(input logic [63:0] v, input int n);
        logic signed [63:0] t;
        t = v << (64 - n);
        return t >>> (64 - n);
    endfunction

    // Kind: 0 none-legal, 1..5 formats, 6 illegal.
    function automatic int kind(input logic [31:0] ins, input bit x64);
        case (ins[6:0])
            7'h13, 7'h03, 7'h67: return 1;
            7'h1B: return x64 ? 1 : 6;
            7'h23: return 2;
            7'h63: return 3;
            7'h37, 7'h17: return 4;
            7'h6F: return 5;
            7'h33, 7'h0F, 7'h73: return 0;
            7'h3B: return x64 ? 0 : 6;
            default: return 6;
        endcase
    endfunction

    function automatic logic [63:0] m_imm(input logic [31:0] ins, input bit x64);
        case (kind(ins, x64))
            1: return sx(64'(ins[31:20]), 12);
            2: return sx(64'({ins[31:25], ins[11:7]}), 12);
            3: return sx(64'({ins[31], ins[7], ins[30:25], ins[11:8]}) * 2, 13);
            4: return sx(64'(ins[31:12]) << 12, 32);
            5: return sx(64'({ins[31], ins[19:12], ins[20], ins[30:21]}) * 2, 21);
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [2:0] m_type(input logic [31:0] ins, input bit x64);
        int k;
        k = kind(ins, x64);
        return (k == 6) ? 3'd0 : 3'(k);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) q.delete();
        else if (flush) q.delete();
        else begin
            bit push, pop;
            push = in_valid && (q.size() < 2);
            pop  = (q.size() > 0) && out_ready;
            if (pop) void'(q.pop_front());
            if (push) q.push_back('{instr: in_instr, pc: in_pc});
        end
    end

    always @(negedge clk) if (rst_n) begin
        chk("valid32", v32, q.size() != 0);
        chk("ready32", r32, q.size() != 2);
        chk("valid64", v64, q.size() != 0);
        chk("ready64", r64, q.size() != 2);
        if (q.size() != 0) begin
            chk("instr32", ins32, q[0].instr);
            chk("pc32", pc32, q[0].pc[31:0]);
            chk("imm32", imm32, m_imm(q[0].instr, 0) & 64'hFFFF_FFFF);
            chk("type32", t32, m_type(q[0].instr, 0));
            chk("ill32", il32, ILL_EN && kind(q[0].instr, 0) == 6);
            chk("instr64", ins64, q[0].instr);
            chk("pc64", pc64, q[0].pc);
            chk("imm64", imm64, m_imm(q[0].instr, 1));
            chk("type64", t64, m_type(q[0].instr, 1));
            chk("ill64", il64, ILL_EN && kind(q[0].instr, 1) == 6);
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic push1(input logic [31:0] ins);
        in_instr = ins; in_pc = {$urandom, $urandom}; in_valid = 1; out_ready = 1;
        step();
        in_valid = 0;
        @(negedge clk);
    endtask

    logic [31:0] opc [16] = '{32'h13, 32'h03, 32'h67, 32'h1B, 32'h23, 32'h63, 32'h37, 32'h17,
                              32'h6F, 32'h33, 32'h0F, 32'h73, 32'h3B, 32'h7F, 32'h00, 32'h2B};

    initial begin
        #2;
        chk("rst_valid", v32, 0); chk("rst_ready", r32, 1);
        chk("rst_instr", ins32, 0); chk("rst_pc", pc64, 0);
        chk("rst_imm", imm64, 0); chk("rst_type", t32, 0); chk("rst_ill", il32, 0);
        #10 rst_n = 1;
        step();

        push1(32'hFFF00093);
        chk("addi_imm", imm32, 32'hFFFF_FFFF); chk("addi_type", t32, 1); chk("addi_ill", il32, 0);
        step();
        push1(32'hFE112E23);
        chk("sw_imm", imm32, 32'hFFFF_FFFC); chk("sw_type", t32, 2);
        step();
        push1(32'h800002B7);
        chk("lui_imm64", imm64, 64'hFFFF_FFFF_8000_0000); chk("lui_type", t64, 4);
        chk("lui_imm32", imm32, 32'h8000_0000);
        step();
        push1(32'h0000007F);
        chk("ill7f_flag", il32, ILL_EN); chk("ill7f_type", t32, 0); chk("ill7f_imm", imm32, 0);
        step();
        push1(32'h0000001B);
        chk("ill1b_flag32", il32, ILL_EN); chk("ill1b_type64", t64, 1); chk("ill1b_flag64", il64, 0);
        step();

        // Back-pressure: A, B accepted, C refused.
        out_ready = 0; in_valid = 1;
        in_instr = 32'h00A00093; step();
        in_instr = 32'h00B00093; step();
        chk("bp_ready_low", r32, 0);
        in_instr = 32'h00C00093; step();
        chk("bp_holdA", ins32, 32'h00A00093);
        in_valid = 0; out_ready = 1;
        @(negedge clk); chk("bp_first", ins32, 32'h00A00093);
        step(); @(negedge clk); chk("bp_second", ins32, 32'h00B00093);
        step(); @(negedge clk); chk("bp_noC", v32, 0);

        // Flush with a full buffer and a live input.
        out_ready = 0; in_valid = 1;
        in_instr = 32'h00100093; step();
        in_instr = 32'h00200093; step();
        flush = 1; in_instr = 32'h00300093; step();
        flush = 0; in_valid = 0;
        chk("fl_valid", v32, 0); chk("fl_ready", r32, 1);
        out_ready = 1; step(); chk("fl_gone", v64, 0);

        // Async reset mid-stream.
        out_ready = 0; in_valid = 1; in_instr = 32'h12345037; step(); in_valid = 0;
        #2 rst_n = 0; #1;
        chk("arst_valid32", v32, 0); chk("arst_valid64", v64, 0);
        @(negedge clk); rst_n = 1;
        step();

        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(9) < 7);
            out_ready = ($urandom_range(9) < 6);
            flush     = ($urandom_range(19) == 0);
            in_instr  = ($urandom & 32'hFFFF_FF80) | opc[$urandom_range(15)];
            if ($urandom_range(15) == 0) in_instr = $urandom;
            in_pc     = {$urandom, $urandom};
            step();
        end
        in_valid = 0; flush = 0;
        step(); step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
